// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read subordinate (AR + R) between NM managers.
// One burst outstanding at a time; the grant holds from arbitration until the RLAST handshake.
module axi4_rd_arbiter #(
  parameter int NM     = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  input  logic [NM*ADDR_W-1:0] M_ARADDR,
  input  logic [NM*3-1:0]      M_ARPROT,
  input  logic [NM-1:0]        M_ARVALID,
  output logic [NM-1:0]        M_ARREADY,
  output logic [NM*DATA_W-1:0] M_RDATA,
  output logic [NM*2-1:0]      M_RRESP,
  output logic [NM-1:0]        M_RLAST,
  output logic [NM-1:0]        M_RVALID,
  input  logic [NM-1:0]        M_RREADY,
  output logic [ADDR_W-1:0]    S_ARADDR,
  output logic [2:0]           S_ARPROT,
  output logic                 S_ARVALID,
  input  logic                 S_ARREADY,
  input  logic [DATA_W-1:0]    S_RDATA,
  input  logic [1:0]           S_RRESP,
  input  logic                 S_RLAST,
  input  logic                 S_RVALID,
  output logic                 S_RREADY
);

  localparam int GW = $clog2(NM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;

  logic [GW-1:0]   arb_idx;
  logic            hi_hit;
  logic [GW-1:0]   hi_idx;
  logic            lo_hit;
  logic [GW-1:0]   lo_idx;

  logic            sel_arvalid;
  logic [ADDR_W-1:0] sel_araddr;
  logic [2:0]      sel_arprot;
  logic            sel_rready;

  logic            ar_done;
  logic            r_done;
  logic [GW-1:0]   ptr_after_grant;

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (M_ARVALID[i] && !lo_hit) begin
        lo_hit = 1'b1;
        lo_idx = GW'(i);
      end
      if (M_ARVALID[i] && !hi_hit && (GW'(i) >= rr_ptr)) begin
        hi_hit = 1'b1;
        hi_idx = GW'(i);
      end
    end
    arb_idx = hi_hit ? hi_idx : lo_idx;
  end

  // Fields of the currently granted manager.
  always_comb begin
    sel_arvalid = 1'b0;
    sel_araddr  = '0;
    sel_arprot  = '0;
    sel_rready  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (grant == GW'(i)) begin
        sel_arvalid = M_ARVALID[i];
        sel_araddr  = M_ARADDR[i*ADDR_W +: ADDR_W];
        sel_arprot  = M_ARPROT[i*3 +: 3];
        sel_rready  = M_RREADY[i];
      end
    end
  end

  assign ar_done         = sel_arvalid && S_ARREADY;
  assign r_done          = S_RVALID && sel_rready && S_RLAST;
  assign ptr_after_grant = (grant == GW'(NM - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge S_AXI_ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (S_AXI_ARESET) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|M_ARVALID) begin
            grant <= arb_idx;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // A manager that withdraws ARVALID loses the grant without moving the pointer.
          if (!sel_arvalid) begin
            state <= ST_IDLE;
          end else if (ar_done) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_done) begin
            rr_ptr <= ptr_after_grant;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output steering: only the granted manager ever sees a non-zero AR ready or R payload.
  always_comb begin
    M_ARREADY = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    M_RLAST   = '0;
    M_RVALID  = '0;
    S_ARADDR  = '0;
    S_ARPROT  = '0;
    S_ARVALID = 1'b0;
    S_RREADY  = 1'b0;
    case (state)
      ST_ADDR: begin
        S_ARVALID = sel_arvalid;
        S_ARADDR  = sel_araddr;
        S_ARPROT  = sel_arprot;
        for (int i = 0; i < NM; i++) begin
          if (grant == GW'(i)) begin
            M_ARREADY[i] = S_ARREADY;
          end
        end
      end
      ST_DATA: begin
        S_RREADY = sel_rready;
        for (int i = 0; i < NM; i++) begin
          if (grant == GW'(i)) begin
            M_RVALID[i]               = S_RVALID;
            M_RDATA[i*DATA_W +: DATA_W] = S_RDATA;
            M_RRESP[i*2 +: 2]         = S_RRESP;
            M_RLAST[i]                = S_RLAST;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
